// File: rtl/md_issue_queue_pkg.sv
// md_pkg: op codes, FSM encoding and queue entry layout shared by the
// mult/div issue queue and its FIFO.
package md_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // 3-bit op + rs + rt
  localparam int ENTRY_W = 3 + 32 + 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_SETTLE = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } md_entry_t;

  // NOP and the unused codes complete the handshake but are never queued
  function automatic logic op_real(input logic [2:0] op);
    return (op >= OP_MULT) && (op <= OP_MTLO);
  endfunction

  // moves finish in the unit immediately, so they skip SETTLE/WAIT
  function automatic logic op_move(input logic [2:0] op);
    return (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

endpackage

// File: rtl/md_issue_queue_fifo.sv
// mdq_fifo: DEPTH x ENTRY_W storage with wrap-bit pointers. The extra top
// pointer bit separates full from empty; occupancy is the pointer difference.
module mdq_fifo
  import md_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ENTRY_W-1:0]       wdata,
  output logic [ENTRY_W-1:0]       rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wptr, rptr;

  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (count == PW'(DEPTH));
  assign rdata = mem[rptr[PW-2:0]];

  // pointer update; both may move in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // storage write; contents are only visible through rptr, so no reset
  always_ff @(posedge clk) begin
    if (push) mem[wptr[PW-2:0]] <= wdata;
  end

endmodule

// File: rtl/md_issue_queue.sv
// md_issue_queue: buffers mult/div/mthi/mtlo ops from E and issues them one
// at a time to the iterative mult/div unit. Optional macro MDQ_BYPASS_EN lets
// an op into an empty, idle queue load the issue registers directly.
module md_issue_queue
  import md_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [2:0]             in_op,
  input  logic [31:0]            in_a,
  input  logic [31:0]            in_b,
  output logic                   in_ready,
  input  logic                   req,
  input  logic                   xalu_busy,
  output logic                   out_valid,
  output logic [2:0]             out_op,
  output logic [31:0]            out_a,
  output logic [31:0]            out_b,
  output logic                   hilo_pending,
  output logic [$clog2(DEPTH):0] occupancy
);

  state_t    state, state_nx;
  md_entry_t in_ent, head, out_ent;
  logic      full, empty, accept, push, pop, bypass;

  assign in_ent   = '{op: in_op, a: in_a, b: in_b};
  // registered occupancy only: no combinational path from a pop to in_ready
  assign in_ready = !full && !req;
  assign accept   = in_valid && in_ready;
  assign pop      = (state == S_IDLE) && !empty && !req;

`ifdef MDQ_BYPASS_EN
  assign bypass = accept && op_real(in_op) && empty && (state == S_IDLE);
`else
  assign bypass = 1'b0;
`endif

  assign push = accept && op_real(in_op) && !bypass;

  mdq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_ent),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next state; xalu_busy is only looked at in WAIT
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (pop || bypass) state_nx = S_ISSUE;
      S_ISSUE:  if (!req) state_nx = op_move(out_ent.op) ? S_IDLE : S_SETTLE;
      S_SETTLE: state_nx = S_WAIT;
      S_WAIT:   if (!xalu_busy) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // issue registers: loaded from the FIFO head, or from E on bypass
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      out_ent <= '0;
    else if (pop)    out_ent <= head;
    else if (bypass) out_ent <= in_ent;
  end

  assign out_valid    = (state == S_ISSUE);
  assign out_op       = out_ent.op;
  assign out_a        = out_ent.a;
  assign out_b        = out_ent.b;
  assign hilo_pending = !empty || (state != S_IDLE);

endmodule

// File: tb/tb_md_issue_queue.sv
// Directed, table-driven bench for md_issue_queue (default DEPTH=4).
// Each table row is one clock cycle: inputs applied after the falling edge,
// outputs compared 1ns later, before the next rising edge.
module tb_md_issue_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, req, xalu_busy;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b;
  logic        in_ready, out_valid, hilo_pending;
  logic [2:0]  out_op;
  logic [31:0] out_a, out_b;
  logic [2:0]  occupancy;

  int n_pass = 0;
  int n_tot  = 0;

  md_issue_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_ready(in_ready), .req(req),
    .xalu_busy(xalu_busy), .out_valid(out_valid), .out_op(out_op),
    .out_a(out_a), .out_b(out_b), .hilo_pending(hilo_pending),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        rq, bsy;
    logic        e_ov;
    logic [2:0]  e_op;
    logic [31:0] e_a, e_b;
    logic [2:0]  e_occ;
    logic        e_rdy, e_hp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                              logic rq, logic bsy, logic e_ov, logic [2:0] e_op,
                              logic [31:0] e_a, logic [31:0] e_b, logic [2:0] e_occ,
                              logic e_rdy, logic e_hp);
    vec_t r;
    r.v = v; r.op = op; r.a = a; r.b = b; r.rq = rq; r.bsy = bsy;
    r.e_ov = e_ov; r.e_op = e_op; r.e_a = e_a; r.e_b = e_b;
    r.e_occ = e_occ; r.e_rdy = e_rdy; r.e_hp = e_hp;
    return r;
  endfunction

  // idle-input row, only status expected
  function automatic vec_t st(logic bsy, logic [2:0] e_occ, logic e_rdy, logic e_hp);
    return mk(0, 0, 0, 0, 0, bsy, 0, 0, 0, 0, e_occ, e_rdy, e_hp);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(logic v, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                       logic rq, logic bsy);
    in_valid = v; in_op = op; in_a = a; in_b = b; req = rq; xalu_busy = bsy;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    // reset state
    #12;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_op", 32'(out_op), 0);
    chk("rst out_a", out_a, 0);
    chk("rst out_b", out_b, 0);
    chk("rst occupancy", 32'(occupancy), 0);
    chk("rst hilo_pending", 32'(hilo_pending), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    req = 1'b1; #1;
    chk("rst in_ready req", 32'(in_ready), 0);
    req = 1'b0;
    @(negedge clk) reset = 1'b1;

`ifndef MDQ_BYPASS_EN
    // A: MULT 3,5 then MTHI; busy held 6 cycles
    tbl.push_back(mk(1, 1, 3, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 5, 9, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 3, 5, 1, 1, 1));
    for (int i = 0; i < 5; i++) tbl.push_back(st(1, 1, 1, 1));
    tbl.push_back(st(0, 1, 1, 1));
    tbl.push_back(st(0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 9, 0, 0, 1, 1));
    tbl.push_back(st(0, 0, 1, 0));
    // B: fill to 4 behind a stalled MULT, 5th rejected, then drain
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 5, 2, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1));
    tbl.push_back(mk(1, 5, 3, 0, 0, 1, 0, 0, 0, 0, 2, 1, 1));
    tbl.push_back(mk(1, 5, 4, 0, 0, 1, 0, 0, 0, 0, 3, 1, 1));
    tbl.push_back(mk(1, 5, 5, 0, 0, 1, 0, 0, 0, 0, 4, 0, 1));
    tbl.push_back(st(0, 4, 0, 1));
    tbl.push_back(st(0, 4, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 1, 0, 3, 1, 1));
    tbl.push_back(st(0, 3, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 2, 0, 2, 1, 1));
    tbl.push_back(st(0, 2, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 3, 0, 1, 1, 1));
    tbl.push_back(st(0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 4, 0, 0, 1, 1));
    tbl.push_back(st(0, 0, 1, 0));
    // C: req held across DIV 7,2 issue; MTHI offered during req is refused
    tbl.push_back(mk(1, 3, 7, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 6, 32'h55, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 5, 32'h99, 0, 1, 0, 1, 3, 7, 2, 1, 0, 1));
    tbl.push_back(mk(1, 5, 32'h99, 0, 1, 0, 1, 3, 7, 2, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 3, 7, 2, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 3, 7, 2, 1, 1, 1));
    tbl.push_back(st(1, 1, 1, 1));
    tbl.push_back(st(0, 1, 1, 1));
    tbl.push_back(st(0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 6, 32'h55, 0, 0, 1, 1));
    tbl.push_back(st(0, 0, 1, 0));
    // D: enqueue + pop at occupancy 2; order MTLO, MULTU, MTHI; then NOP/op7
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 6, 32'h11, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 2, 32'h22, 32'h33, 0, 1, 1, 1, 0, 0, 1, 1, 1));
    tbl.push_back(st(1, 2, 1, 1));
    tbl.push_back(st(0, 2, 1, 1));
    tbl.push_back(mk(1, 5, 32'h44, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 6, 32'h11, 0, 2, 1, 1));
    tbl.push_back(st(0, 2, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 2, 32'h22, 32'h33, 1, 1, 1));
    tbl.push_back(st(1, 1, 1, 1));
    tbl.push_back(st(0, 1, 1, 1));
    tbl.push_back(st(0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 32'h44, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 32'hAA, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 7, 32'hBB, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(st(0, 0, 1, 0));
    tbl.push_back(st(0, 0, 1, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rq, tbl[i].bsy);
      #1;
      chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("row%0d occupancy", i), 32'(occupancy), 32'(tbl[i].e_occ));
      chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d hilo_pending", i), 32'(hilo_pending), 32'(tbl[i].e_hp));
      if (tbl[i].e_ov) begin
        chk($sformatf("row%0d out_op", i), 32'(out_op), 32'(tbl[i].e_op));
        chk($sformatf("row%0d out_a", i), out_a, tbl[i].e_a);
        chk($sformatf("row%0d out_b", i), out_b, tbl[i].e_b);
      end
    end
`endif

    // asynchronous reset while in WAIT with two ops queued
    @(negedge clk) drive(1, 1, 32'h6, 32'h7, 0, 1);
    @(negedge clk) drive(1, 5, 32'h1, 0, 0, 1);
    @(negedge clk) drive(1, 6, 32'h2, 0, 0, 1);
    @(negedge clk) drive(0, 0, 0, 0, 0, 1);
    @(negedge clk); #1;
    chk("prerst occupancy", 32'(occupancy), 2);
    chk("prerst out_valid", 32'(out_valid), 0);
    chk("prerst hilo_pending", 32'(hilo_pending), 1);
    #1 reset = 1'b0;
    #1;
    chk("midrst occupancy", 32'(occupancy), 0);
    chk("midrst out_valid", 32'(out_valid), 0);
    chk("midrst hilo_pending", 32'(hilo_pending), 0);
    chk("midrst out_op", 32'(out_op), 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk); #1;
    chk("postrst occupancy", 32'(occupancy), 0);
    chk("postrst out_valid", 32'(out_valid), 0);

`ifdef MDQ_BYPASS_EN
    // bypass: MTLO straight to the issue registers, FIFO untouched
    @(negedge clk) drive(1, 6, 32'h1234, 0, 0, 0);
    #1;
    chk("byp t occupancy", 32'(occupancy), 0);
    chk("byp t in_ready", 32'(in_ready), 1);
    @(negedge clk) drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("byp t+1 out_valid", 32'(out_valid), 1);
    chk("byp t+1 out_op", 32'(out_op), 6);
    chk("byp t+1 out_a", out_a, 32'h1234);
    chk("byp t+1 occupancy", 32'(occupancy), 0);
    chk("byp t+1 hilo_pending", 32'(hilo_pending), 1);
    @(negedge clk); #1;
    chk("byp t+2 out_valid", 32'(out_valid), 0);
    chk("byp t+2 occupancy", 32'(occupancy), 0);
    chk("byp t+2 hilo_pending", 32'(hilo_pending), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
